// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-stage bus between the PC sequencer and its datapath/ROM side.
// FETCH_PERF_CNT_EN adds the FetchCount performance counter signal.
interface inst_fetch_ctrl_if #(
  parameter int A = 10,
  parameter int W = 9
);
  logic         Start;
  logic [A-1:0] StartAddr;
  logic         Stall;
  logic         BranchEn;
  logic         BranchAbs;
  logic [A-1:0] Target;
  logic [W-1:0] InstIn;
  logic [A-1:0] InstAddress;
  logic         Valid;
  logic         Done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]  FetchCount;

  modport master (
    input  Start, StartAddr, Stall, BranchEn, BranchAbs, Target, InstIn,
    output InstAddress, Valid, Done, FetchCount
  );
  modport slave (
    output Start, StartAddr, Stall, BranchEn, BranchAbs, Target, InstIn,
    input  InstAddress, Valid, Done, FetchCount
  );
`else
  modport master (
    input  Start, StartAddr, Stall, BranchEn, BranchAbs, Target, InstIn,
    output InstAddress, Valid, Done
  );
  modport slave (
    output Start, StartAddr, Stall, BranchEn, BranchAbs, Target, InstIn,
    input  InstAddress, Valid, Done
  );
`endif
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Program counter and fetch sequencer in front of the instruction ROM.
// IDLE -> RUN on Start; RUN advances, branches, stalls or halts on
// HALT_WORD; HALTED waits for a new Start. Valid/Done are Moore outputs.
// Optional macro FETCH_PERF_CNT_EN adds a saturating 16-bit FetchCount.
module inst_fetch_ctrl #(
  parameter int           A         = 10,
  parameter int           W         = 9,
  parameter logic [W-1:0] HALT_WORD = 9'b111111111
) (
  input logic               Clk,
  input logic               Reset,
  inst_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t       state;
  logic [A-1:0] pc;
  logic         valid_q;
  logic         done_q;
  logic         halt_hit;
  logic [A-1:0] pc_next_run;

  assign halt_hit = (bus.InstIn == HALT_WORD);

  // Next PC for an unstalled, non-halting RUN cycle; the A-bit adds wrap
  // modulo 2**A, which also gives two's-complement relative branches.
  always_comb begin
    pc_next_run = pc + {{(A-1){1'b0}}, 1'b1};
    if (bus.BranchEn) begin
      if (bus.BranchAbs) pc_next_run = bus.Target;
      else               pc_next_run = pc + bus.Target;
    end
  end

  // Fetch FSM with PC and registered Valid/Done.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      pc      <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            pc      <= bus.StartAddr;
            state   <= RUN;
            valid_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.Start) begin
            pc <= bus.StartAddr;
          end else if (bus.Stall) begin
            pc <= pc;
          end else if (halt_hit) begin
            state   <= HALTED;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc <= pc_next_run;
          end
        end
        HALTED: begin
          if (bus.Start) begin
            pc      <= bus.StartAddr;
            state   <= RUN;
            valid_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InstAddress = pc;
  assign bus.Valid       = valid_q;
  assign bus.Done        = done_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic        fetch_step;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A counted fetch is a RUN cycle whose PC moves by advance or branch.
  assign fetch_step = (state == RUN) && !bus.Start && !bus.Stall && !halt_hit;

  // Saturating fetch counter, cleared by every accepted Start.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)           fetch_cnt <= '0;
    else if (bus.Start)  fetch_cnt <= '0;
    else if (fetch_step) fetch_cnt <= sat_inc16(fetch_cnt);
  end

  assign bus.FetchCount = fetch_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares one entry per cycle.
module tb_inst_fetch_ctrl;
  localparam int A = 10;
  localparam int W = 9;
  localparam logic [W-1:0] HALT = 9'h1FF;

  logic Clk = 1'b0;
  logic Reset;
  int checks = 0;
  int errors = 0;

  logic         halt_en;
  logic [A-1:0] halt_at;

  typedef struct {
    logic [A-1:0] a;
    logic         v;
    logic         d;
    logic [15:0]  c;
    string        nm;
  } exp_t;
  exp_t sb[$];

  inst_fetch_ctrl_if #(.A(A), .W(W)) bus ();

  inst_fetch_ctrl #(.A(A), .W(W), .HALT_WORD(HALT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // ROM model: one configurable halt location, everything else non-halt.
  always_comb begin
    bus.InstIn = 9'h012;
    if (halt_en && bus.InstAddress == halt_at) bus.InstIn = HALT;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.nm, ".addr"},  32'(bus.InstAddress), 32'(e.a));
    chk({e.nm, ".valid"}, 32'(bus.Valid),       32'(e.v));
    chk({e.nm, ".done"},  32'(bus.Done),        32'(e.d));
`ifdef FETCH_PERF_CNT_EN
    chk({e.nm, ".cnt"},   32'(bus.FetchCount),  32'(e.c));
`endif
  endtask

  // Monitor: after each active edge, compare against the oldest expectation.
  always @(posedge Clk) begin
    #1;
    if (sb.size() > 0) chk_all(sb.pop_front());
  end

  task automatic drive(input logic st, input logic [A-1:0] sa, input logic stl,
                       input logic be, input logic ba, input logic [A-1:0] tg);
    bus.Start = st; bus.StartAddr = sa; bus.Stall = stl;
    bus.BranchEn = be; bus.BranchAbs = ba; bus.Target = tg;
  endtask

  task automatic cyc(input logic [A-1:0] ea, input logic ev, input logic ed,
                     input logic [15:0] ec, input string nm);
    exp_t e;
    e.a = ea; e.v = ev; e.d = ed; e.c = ec; e.nm = nm;
    sb.push_back(e);
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    Reset = 1'b1; halt_en = 1'b0; halt_at = '0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge Clk);
    r.a = 0; r.v = 0; r.d = 0; r.c = 0; r.nm = "reset";
    chk_all(r);
    Reset = 1'b0;
    @(negedge Clk);

    // Straight-line program halting at word 4
    halt_en = 1'b1; halt_at = 10'd4;
    drive(1, 0, 0, 0, 0, 0);     cyc(0, 1, 0, 0, "start0");
    drive(0, 0, 0, 0, 0, 0);     cyc(1, 1, 0, 1, "adv1");
                                 cyc(2, 1, 0, 2, "adv2");
                                 cyc(3, 1, 0, 3, "adv3");
                                 cyc(4, 1, 0, 4, "adv4");
                                 cyc(4, 0, 1, 4, "halt4");
    drive(0, 0, 0, 1, 1, 9);     cyc(4, 0, 1, 4, "halted_hold");

    // Restart from HALTED, then relative and absolute branches
    halt_en = 1'b0;
    drive(1, 10, 0, 0, 0, 0);    cyc(10, 1, 0, 0, "restart10");
    drive(0, 0, 0, 1, 0, 10'h3FD); cyc(7, 1, 0, 1, "rel_m3");
    drive(0, 0, 0, 1, 1, 10'd200); cyc(200, 1, 0, 2, "abs200");

    // Address wrap both ways
    drive(1, 10'd1022, 0, 0, 0, 0); cyc(1022, 1, 0, 0, "start1022");
    drive(0, 0, 0, 0, 0, 0);     cyc(1023, 1, 0, 1, "adv1023");
                                 cyc(0, 1, 0, 2, "wrap0");
                                 cyc(1, 1, 0, 3, "adv1");
    drive(0, 0, 0, 1, 0, 10'h3FE); cyc(1023, 1, 0, 4, "rel_wrap");

    // Stall masks halt and branch, then halt wins over branch
    drive(1, 10'd5, 0, 0, 0, 0); cyc(5, 1, 0, 0, "start5");
    halt_en = 1'b1; halt_at = 10'd5;
    drive(0, 0, 1, 1, 1, 10'd100);
    for (int i = 0; i < 3; i++) cyc(5, 1, 0, 0, "stall5");
    drive(0, 0, 0, 1, 1, 10'd100); cyc(5, 0, 1, 0, "halt5");

    // Start in HALTED, then Start overriding Stall in RUN
    halt_en = 1'b0;
    drive(1, 10'd50, 0, 0, 0, 0); cyc(50, 1, 0, 0, "start50");
    drive(0, 0, 0, 0, 0, 0);     cyc(51, 1, 0, 1, "adv51");
    drive(1, 10'd3, 1, 1, 1, 10'd99); cyc(3, 1, 0, 0, "start_over_stall");
    drive(0, 0, 0, 0, 0, 0);     cyc(4, 1, 0, 1, "adv4b");

    // Asynchronous reset mid-cycle in RUN
    drive(1, 10'd77, 0, 0, 0, 0); cyc(77, 1, 0, 0, "start77");
    drive(0, 0, 0, 0, 0, 0);
    #2 Reset = 1'b1;
    #1;
    r.a = 0; r.v = 0; r.d = 0; r.c = 0; r.nm = "async_reset";
    chk_all(r);
    @(negedge Clk);
    Reset = 1'b0;
    drive(0, 10'd33, 0, 1, 1, 10'd44);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, "idle_hold");
    drive(1, 10'd9, 0, 0, 0, 0); cyc(9, 1, 0, 0, "start9");
    drive(0, 0, 0, 0, 0, 0);     cyc(10, 1, 0, 1, "adv10");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
